hold_request_ctrl: RTL and testbench
====================================

// Module: hold_request_ctrl
// PURPOSE
//  Initiator side of the 2-second hold timer interface. Game FSM hands over a value
//  (card/message code); block latches it, clears and enables the timer, holds
//  the value valid until timer reports expiry, then signals completion.
//  Watchdog flags a dead timer. Sits between game FSM and hold timer, clk_50M domain.
// PARAMETERS
//  DATA_W     6            width of latched value (i_Data/o_Data)
//  WD_CYCLES  110_000_000  max clk_50M cycles in WAIT_LOW+RUN before error (2.2 s)
//  WD_W       27           watchdog counter width; must hold WD_CYCLES-1
// PORTS
//  clk_50M   in   1       system clock, 50 MHz, all logic on rising edge
//  i_Reset   in   1       reset, asynchronous, active-high
//  i_Req     in   1       request valid; requester holds it (and i_Data) until o_Ack
//  i_Data    in   DATA_W  value to display during hold
//  i_Abort   in   1       cancel current hold
//  i_TwoSec  in   1       timer expiry flag (level, from hold timer)
//  o_Ack     out  1       1-cycle pulse: request accepted, i_Data latched
//  o_Zero    out  1       1-cycle pulse: clear timer count
//  o_Active  out  1       level: enable timer counting
//  o_Data    out  DATA_W  latched value
//  o_Valid   out  1       o_Data being held
//  o_Done    out  1       1-cycle pulse: hold completed normally
//  o_Error   out  1       sticky: watchdog expired
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; o_Data=0; watchdog=0.
//  All outputs registered (change one cycle after deciding edge).
//  IDLE: o_Active=0. On i_Req=1: latch i_Data->o_Data, o_Ack=1, o_Valid=1,
//   o_Error=0, watchdog=0 -> CLEAR. i_Req ignored in every other state (no ack).
//  CLEAR: o_Zero=1 for exactly one cycle -> WAIT_LOW.
//  WAIT_LOW: o_Zero=0, o_Active=0; wait i_TwoSec=0 (stale expiry cleared);
//   watchdog counts; on i_TwoSec=0 -> RUN.
//  RUN: o_Active=1; watchdog counts each cycle; on i_TwoSec=1 -> DONE.
//  DONE: o_Done=1 one cycle, o_Active=0, o_Valid=0 -> IDLE. o_Data keeps value
//   until next accept.
//  Watchdog: counts in WAIT_LOW/RUN; reaching WD_CYCLES-1 without exit ->
//   o_Error=1, o_Active=0, o_Valid=0, no o_Done -> IDLE. Saturates, no wrap.
//  Abort: i_Abort=1 in CLEAR/WAIT_LOW/RUN/DONE -> IDLE next cycle, o_Active=0,
//   o_Valid=0, no o_Done, o_Error unchanged. Ignored in IDLE.
//  Priority same cycle: i_Abort > i_TwoSec > watchdog terminal.
//  Back-to-back: min one IDLE cycle between o_Done and next o_Ack; a held
//   i_Req is accepted in that IDLE cycle.
//  Reset mid-hold: immediate return to reset state, o_Active drops async.
//  o_Ack, o_Zero, o_Done never high in same cycle.
// TESTING (WD_CYCLES=20, WD_W=5, DATA_W=6)
//  1 Reset: assert i_Reset mid-RUN -> all outputs 0 same cycle, state IDLE.
//  2 Normal: i_Req=1,i_Data=6'h2A; timer TwoSec 10 cycles after o_Active ->
//    o_Ack 1 cycle, o_Zero 1 cycle later, o_Active high, o_Done once, o_Data=2A.
//  3 Stale expiry: i_TwoSec=1 at request, drops 3 cycles after o_Zero ->
//    o_Active stays 0 until i_TwoSec low, then normal completion.
//  4 Watchdog: i_TwoSec stuck 0 -> o_Error=1 after 20 cycles, no o_Done;
//    next i_Req clears o_Error.
//  5 Abort+expiry same cycle in RUN -> IDLE, no o_Done, o_Valid=0.
//  6 Busy request: second i_Req(6'h15) during RUN -> no o_Ack until after
//    o_Done + 1 IDLE cycle; then o_Data=15.

Source files
------------

// File: rtl/hold_request_ctrl.sv
// Purpose: initiator side of the hold-timer handshake; latches a value, clears and runs the timer, signals completion or watchdog error.
// Latency: every output is registered and changes one clk_50M cycle after the deciding edge; o_Ack follows i_Req by one cycle.
// Backpressure: i_Req is honoured only in IDLE; a requester holds i_Req/i_Data until o_Ack, and a busy block simply withholds o_Ack.
module hold_request_ctrl #(
    parameter int DATA_W    = 6,
    parameter int WD_CYCLES = 110_000_000,
    parameter int WD_W      = 27
) (
    input  logic              clk_50M,
    input  logic              i_Reset,
    input  logic              i_Req,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Abort,
    input  logic              i_TwoSec,
    output logic              o_Ack,
    output logic              o_Zero,
    output logic              o_Active,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_Valid,
    output logic              o_Done,
    output logic              o_Error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_WAIT_LOW = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Last watchdog count before the timer is declared dead.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

    state_t            r_State;
    logic [WD_W-1:0]   r_Wd;
    logic              r_Ack;
    logic              r_Zero;
    logic              r_Active;
    logic [DATA_W-1:0] r_Data;
    logic              r_Valid;
    logic              r_Done;
    logic              r_Error;

    logic              w_WdTerm;
    logic [WD_W-1:0]   w_WdNext;

    // Watchdog terminal detect and saturating increment (never wraps).
    assign w_WdTerm = (r_Wd == WD_LAST);
    assign w_WdNext = w_WdTerm ? r_Wd : (r_Wd + WD_W'(1));

    // Control FSM with registered outputs; abort beats expiry, expiry beats watchdog.
    always_ff @(posedge clk_50M or posedge i_Reset) begin
        if (i_Reset) begin
            r_State  <= S_IDLE;
            r_Wd     <= '0;
            r_Ack    <= 1'b0;
            r_Zero   <= 1'b0;
            r_Active <= 1'b0;
            r_Data   <= '0;
            r_Valid  <= 1'b0;
            r_Done   <= 1'b0;
            r_Error  <= 1'b0;
        end else begin
            // Pulse outputs default low so each is high for exactly one cycle.
            r_Ack  <= 1'b0;
            r_Zero <= 1'b0;
            r_Done <= 1'b0;

            case (r_State)
                S_IDLE: begin
                    r_Active <= 1'b0;
                    if (i_Req) begin
                        r_Data  <= i_Data;
                        r_Ack   <= 1'b1;
                        r_Valid <= 1'b1;
                        r_Error <= 1'b0;
                        r_Wd    <= '0;
                        r_State <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (i_Abort) begin
                        r_Active <= 1'b0;
                        r_Valid  <= 1'b0;
                        r_State  <= S_IDLE;
                    end else begin
                        r_Zero  <= 1'b1;
                        r_State <= S_WAIT_LOW;
                    end
                end

                S_WAIT_LOW: begin
                    // Wait for a stale expiry from a previous hold to clear.
                    if (i_Abort) begin
                        r_Active <= 1'b0;
                        r_Valid  <= 1'b0;
                        r_State  <= S_IDLE;
                    end else if (!i_TwoSec) begin
                        r_Wd     <= w_WdNext;
                        r_Active <= 1'b1;
                        r_State  <= S_RUN;
                    end else if (w_WdTerm) begin
                        r_Error  <= 1'b1;
                        r_Active <= 1'b0;
                        r_Valid  <= 1'b0;
                        r_State  <= S_IDLE;
                    end else begin
                        r_Wd <= w_WdNext;
                    end
                end

                S_RUN: begin
                    if (i_Abort) begin
                        r_Active <= 1'b0;
                        r_Valid  <= 1'b0;
                        r_State  <= S_IDLE;
                    end else if (i_TwoSec) begin
                        r_Done   <= 1'b1;
                        r_Active <= 1'b0;
                        r_Valid  <= 1'b0;
                        r_State  <= S_DONE;
                    end else if (w_WdTerm) begin
                        r_Error  <= 1'b1;
                        r_Active <= 1'b0;
                        r_Valid  <= 1'b0;
                        r_State  <= S_IDLE;
                    end else begin
                        r_Wd     <= w_WdNext;
                        r_Active <= 1'b1;
                    end
                end

                S_DONE: begin
                    // One idle cycle always separates o_Done from the next o_Ack.
                    r_Active <= 1'b0;
                    r_Valid  <= 1'b0;
                    r_State  <= S_IDLE;
                end

                default: begin
                    r_Active <= 1'b0;
                    r_Valid  <= 1'b0;
                    r_State  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Ack    = r_Ack;
    assign o_Zero   = r_Zero;
    assign o_Active = r_Active;
    assign o_Data   = r_Data;
    assign o_Valid  = r_Valid;
    assign o_Done   = r_Done;
    assign o_Error  = r_Error;

endmodule

// File: tb/tb_hold_request_ctrl.sv
// Purpose: table-driven, cycle-exact check of hold_request_ctrl with WD_CYCLES=20.
// Latency: each vector drives inputs at negedge and checks outputs 1 time unit after the next posedge.
// Backpressure: none; stimulus is fixed per cycle, expectations flow through a scoreboard queue.
module tb_hold_request_ctrl;

    logic       clk_50M = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Req   = 1'b0;
    logic [5:0] i_Data  = '0;
    logic       i_Abort = 1'b0;
    logic       i_TwoSec = 1'b0;
    logic       o_Ack, o_Zero, o_Active, o_Valid, o_Done, o_Error;
    logic [5:0] o_Data;

    hold_request_ctrl #(.DATA_W(6), .WD_CYCLES(20), .WD_W(5)) dut (
        .clk_50M (clk_50M),
        .i_Reset (i_Reset),
        .i_Req   (i_Req),
        .i_Data  (i_Data),
        .i_Abort (i_Abort),
        .i_TwoSec(i_TwoSec),
        .o_Ack   (o_Ack),
        .o_Zero  (o_Zero),
        .o_Active(o_Active),
        .o_Data  (o_Data),
        .o_Valid (o_Valid),
        .o_Done  (o_Done),
        .o_Error (o_Error)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        int         test;
        logic       req;
        logic [5:0] data;
        logic       abort;
        logic       two;
        logic [11:0] exp;   // {ack, zero, active, data[5:0], valid, done, error}
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [11:0] pack(logic ack, logic zero, logic act, logic [5:0] d,
                                         logic v, logic dn, logic e);
        return {ack, zero, act, d, v, dn, e};
    endfunction

    function automatic void add(int t, logic req, logic [5:0] d, logic ab, logic two,
                                logic ack, logic zero, logic act, logic [5:0] od,
                                logic v, logic dn, logic e);
        vec_t x;
        x.test = t; x.req = req; x.data = d; x.abort = ab; x.two = two;
        x.exp  = pack(ack, zero, act, od, v, dn, e);
        vecs.push_back(x);
    endfunction

    function automatic logic [11:0] actual();
        return {o_Ack, o_Zero, o_Active, o_Data, o_Valid, o_Done, o_Error};
    endfunction

    task automatic compare(string name, int idx);
        logic [11:0] want;
        logic [11:0] got;
        got = actual();
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s #%0d scoreboard empty, got %h", name, idx, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL %s #%0d got %h want %h (ack,zero,act,data,valid,done,err)",
                         name, idx, got, want);
            end
        end
    endtask

    task automatic apply(vec_t x, int idx);
        @(negedge clk_50M);
        i_Req = x.req; i_Data = x.data; i_Abort = x.abort; i_TwoSec = x.two;
        exp_q.push_back(x.exp);
        @(posedge clk_50M);
        #1;
        compare($sformatf("test%0d_vec", x.test), idx);
    endtask

    initial begin
        // Test 2: normal hold of 6'h2A, expiry 10 cycles after o_Active rises.
        add(2, 1, 6'h2A, 0, 0,  1, 0, 0, 6'h2A, 1, 0, 0);
        add(2, 0, 6'h00, 0, 0,  0, 1, 0, 6'h2A, 1, 0, 0);
        add(2, 0, 6'h00, 0, 0,  0, 0, 1, 6'h2A, 1, 0, 0);
        for (int i = 0; i < 9; i++) add(2, 0, 6'h00, 0, 0,  0, 0, 1, 6'h2A, 1, 0, 0);
        add(2, 0, 6'h00, 0, 1,  0, 0, 0, 6'h2A, 0, 1, 0);
        add(2, 0, 6'h00, 0, 1,  0, 0, 0, 6'h2A, 0, 0, 0);
        add(2, 0, 6'h00, 0, 1,  0, 0, 0, 6'h2A, 0, 0, 0);
        // Test 3: stale expiry high at request, drops three cycles after o_Zero.
        add(3, 1, 6'h11, 0, 1,  1, 0, 0, 6'h11, 1, 0, 0);
        add(3, 0, 6'h00, 0, 1,  0, 1, 0, 6'h11, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(3, 0, 6'h00, 0, 1,  0, 0, 0, 6'h11, 1, 0, 0);
        add(3, 0, 6'h00, 0, 0,  0, 0, 1, 6'h11, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(3, 0, 6'h00, 0, 0,  0, 0, 1, 6'h11, 1, 0, 0);
        add(3, 0, 6'h00, 0, 1,  0, 0, 0, 6'h11, 0, 1, 0);
        add(3, 0, 6'h00, 0, 1,  0, 0, 0, 6'h11, 0, 0, 0);
        // Test 4: dead timer; error after 20 WAIT_LOW+RUN cycles, cleared by next request.
        add(4, 1, 6'h3C, 0, 0,  1, 0, 0, 6'h3C, 1, 0, 0);
        add(4, 0, 6'h00, 0, 0,  0, 1, 0, 6'h3C, 1, 0, 0);
        add(4, 0, 6'h00, 0, 0,  0, 0, 1, 6'h3C, 1, 0, 0);
        for (int i = 0; i < 18; i++) add(4, 0, 6'h00, 0, 0,  0, 0, 1, 6'h3C, 1, 0, 0);
        add(4, 0, 6'h00, 0, 0,  0, 0, 0, 6'h3C, 0, 0, 1);
        add(4, 0, 6'h00, 0, 0,  0, 0, 0, 6'h3C, 0, 0, 1);
        add(4, 1, 6'h01, 0, 0,  1, 0, 0, 6'h01, 1, 0, 0);
        add(4, 0, 6'h00, 1, 0,  0, 0, 0, 6'h01, 0, 0, 0);
        add(4, 0, 6'h00, 0, 0,  0, 0, 0, 6'h01, 0, 0, 0);
        // Test 5: abort and expiry in the same RUN cycle.
        add(5, 1, 6'h07, 0, 0,  1, 0, 0, 6'h07, 1, 0, 0);
        add(5, 0, 6'h00, 0, 0,  0, 1, 0, 6'h07, 1, 0, 0);
        add(5, 0, 6'h00, 0, 0,  0, 0, 1, 6'h07, 1, 0, 0);
        add(5, 0, 6'h00, 0, 0,  0, 0, 1, 6'h07, 1, 0, 0);
        add(5, 0, 6'h00, 1, 1,  0, 0, 0, 6'h07, 0, 0, 0);
        add(5, 0, 6'h00, 0, 1,  0, 0, 0, 6'h07, 0, 0, 0);
        add(5, 0, 6'h00, 0, 0,  0, 0, 0, 6'h07, 0, 0, 0);
        // Test 6: request 6'h15 held during RUN, accepted one idle cycle after o_Done.
        add(6, 1, 6'h0F, 0, 0,  1, 0, 0, 6'h0F, 1, 0, 0);
        add(6, 0, 6'h00, 0, 0,  0, 1, 0, 6'h0F, 1, 0, 0);
        add(6, 0, 6'h00, 0, 0,  0, 0, 1, 6'h0F, 1, 0, 0);
        add(6, 1, 6'h15, 0, 0,  0, 0, 1, 6'h0F, 1, 0, 0);
        add(6, 1, 6'h15, 0, 0,  0, 0, 1, 6'h0F, 1, 0, 0);
        add(6, 1, 6'h15, 0, 1,  0, 0, 0, 6'h0F, 0, 1, 0);
        add(6, 1, 6'h15, 0, 1,  0, 0, 0, 6'h0F, 0, 0, 0);
        add(6, 1, 6'h15, 0, 1,  1, 0, 0, 6'h15, 1, 0, 0);
        add(6, 0, 6'h00, 0, 1,  0, 1, 0, 6'h15, 1, 0, 0);
        add(6, 0, 6'h00, 0, 1,  0, 0, 0, 6'h15, 1, 0, 0);
        add(6, 0, 6'h00, 1, 1,  0, 0, 0, 6'h15, 0, 0, 0);
        add(6, 0, 6'h00, 0, 0,  0, 0, 0, 6'h15, 0, 0, 0);
        // Test 1 lead-in: bring a 6'h33 hold into RUN before the async reset.
        add(1, 1, 6'h33, 0, 0,  1, 0, 0, 6'h33, 1, 0, 0);
        add(1, 0, 6'h00, 0, 0,  0, 1, 0, 6'h33, 1, 0, 0);
        add(1, 0, 6'h00, 0, 0,  0, 0, 1, 6'h33, 1, 0, 0);
        add(1, 0, 6'h00, 0, 0,  0, 0, 1, 6'h33, 1, 0, 0);

        // Power-on reset state.
        repeat (2) @(posedge clk_50M);
        #1;
        exp_q.push_back(12'h000);
        compare("reset_state", 0);
        @(negedge clk_50M);
        i_Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Test 1: asynchronous reset mid-RUN clears outputs within the same cycle.
        @(negedge clk_50M);
        #2;
        i_Reset = 1'b1;
        #1;
        exp_q.push_back(12'h000);
        compare("async_reset_same_cycle", 0);
        @(posedge clk_50M);
        #1;
        exp_q.push_back(12'h000);
        compare("reset_held", 0);
        @(negedge clk_50M);
        i_Reset = 1'b0;
        begin
            vec_t x;
            x.test = 1; x.req = 1'b0; x.data = 6'h00; x.abort = 1'b0; x.two = 1'b0;
            x.exp  = 12'h000;
            apply(x, 0);
            // A fresh request after reset is accepted normally.
            x.req = 1'b1; x.data = 6'h2C; x.exp = pack(1, 0, 0, 6'h2C, 1, 0, 0);
            apply(x, 1);
            x.req = 1'b0; x.data = 6'h00; x.exp = pack(0, 1, 0, 6'h2C, 1, 0, 0);
            apply(x, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
